// File: rtl/dff_pipe_vr.sv
`default_nettype none
// ============================================================================
// Module : dff_pipe_vr
// Multi-stage valid/ready register pipeline with bubble collapsing,
// per-stage reset value and synchronous flush.
// Rev    : 1.0
// ============================================================================
module dff_pipe_vr #(
  parameter  int Width = 8,
  parameter  int Depth = 2,
  localparam int OccW  = $clog2(Depth + 1)
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic [Width-1:0] DRST,
  input  logic             FLUSH,
  input  logic             IN_VALID,
  input  logic [Width-1:0] IN_DATA,
  output logic             IN_READY,
  output logic             OUT_VALID,
  output logic [Width-1:0] OUT_DATA,
  input  logic             OUT_READY,
  output logic [OccW-1:0]  OCC
);

  logic [Depth-1:0] v_q;
  logic [Depth-1:0] v_d;
  logic [Depth-1:0] rdy;
  logic [Width-1:0] d_q [Depth];
  logic [Width-1:0] d_d [Depth];
  logic             w_chain;

  // A stage is ready when it is empty or everything downstream of it can move.
  always_comb begin
    rdy     = '0;
    w_chain = OUT_READY;
    for (int i = Depth - 1; i >= 0; i--) begin
      w_chain = ~v_q[i] | w_chain;
      rdy[i]  = w_chain;
    end
  end

  for (genvar gi = 0; gi < Depth; gi++) begin : g_stage
    logic             w_vin;
    logic [Width-1:0] w_din;
    if (gi == 0) begin : g_head
      assign w_vin = IN_VALID;
      assign w_din = IN_DATA;
    end else begin : g_body
      assign w_vin = v_q[gi-1];
      assign w_din = d_q[gi-1];
    end
    assign v_d[gi] = ~FLUSH & (rdy[gi] ? w_vin : v_q[gi]);
    // Data only moves with a valid beat and never during flush, so idle stages stay quiet.
    assign d_d[gi] = (rdy[gi] & w_vin & ~FLUSH) ? w_din : d_q[gi];
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      v_q <= '0;
      for (int i = 0; i < Depth; i++) d_q[i] <= DRST;
    end else begin
      v_q <= v_d;
      for (int i = 0; i < Depth; i++) d_q[i] <= d_d[i];
    end
  end

  assign IN_READY  = rdy[0];
  assign OUT_VALID = v_q[Depth-1];
  assign OUT_DATA  = d_q[Depth-1];

  always_comb begin
    OCC = '0;
    for (int i = 0; i < Depth; i++) OCC = OCC + OccW'(v_q[i]);
  end

`ifndef SYNTHESIS
  logic             stall_q;
  logic [Width-1:0] stall_data_q;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) stall_q <= 1'b0;
    else       stall_q <= OUT_VALID & ~OUT_READY & ~FLUSH;
  end

  always_ff @(posedge CLK) begin
    stall_data_q <= OUT_DATA;
  end

  always_ff @(posedge CLK) begin
    if (RSTN) begin
      assert (!$isunknown(v_q));
      if (stall_q) assert (OUT_VALID && (OUT_DATA == stall_data_q));
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dff_pipe_vr.sv
`default_nettype none
// ============================================================================
// Module : tb_dff_pipe_vr
// Self-checking bench for dff_pipe_vr: directed scenarios plus random traffic
// against a beat-list reference model over several Width/Depth configurations.
// Rev    : 1.0
// ============================================================================
module tb_dff_pipe_vr;

  localparam int NI   = 5;
  localparam int MAXD = 5;

  logic        clk = 1'b0;
  logic        rstn, flush, in_valid, out_ready;
  logic [63:0] drst, in_data;

  always #5 clk = ~clk;

  // Instance 0: W8/D3, 1: W8/D4, 2: W1/D1, 3: W8/D2, 4: W64/D5
  logic r0, r1, r2, r3, r4;
  logic v0, v1, v2, v3, v4;
  logic [7:0]  d0, d1, d3;
  logic [0:0]  d2;
  logic [63:0] d4;
  logic [1:0]  c0, c3;
  logic [2:0]  c1, c4;
  logic [0:0]  c2;

  dff_pipe_vr #(.Width(8), .Depth(3)) u_w8d3 (.CLK(clk), .RSTN(rstn), .DRST(drst[7:0]),
    .FLUSH(flush), .IN_VALID(in_valid), .IN_DATA(in_data[7:0]), .IN_READY(r0),
    .OUT_VALID(v0), .OUT_DATA(d0), .OUT_READY(out_ready), .OCC(c0));
  dff_pipe_vr #(.Width(8), .Depth(4)) u_w8d4 (.CLK(clk), .RSTN(rstn), .DRST(drst[7:0]),
    .FLUSH(flush), .IN_VALID(in_valid), .IN_DATA(in_data[7:0]), .IN_READY(r1),
    .OUT_VALID(v1), .OUT_DATA(d1), .OUT_READY(out_ready), .OCC(c1));
  dff_pipe_vr #(.Width(1), .Depth(1)) u_w1d1 (.CLK(clk), .RSTN(rstn), .DRST(drst[0:0]),
    .FLUSH(flush), .IN_VALID(in_valid), .IN_DATA(in_data[0:0]), .IN_READY(r2),
    .OUT_VALID(v2), .OUT_DATA(d2), .OUT_READY(out_ready), .OCC(c2));
  dff_pipe_vr #(.Width(8), .Depth(2)) u_w8d2 (.CLK(clk), .RSTN(rstn), .DRST(drst[7:0]),
    .FLUSH(flush), .IN_VALID(in_valid), .IN_DATA(in_data[7:0]), .IN_READY(r3),
    .OUT_VALID(v3), .OUT_DATA(d3), .OUT_READY(out_ready), .OCC(c3));
  dff_pipe_vr #(.Width(64), .Depth(5)) u_w64d5 (.CLK(clk), .RSTN(rstn), .DRST(drst),
    .FLUSH(flush), .IN_VALID(in_valid), .IN_DATA(in_data), .IN_READY(r4),
    .OUT_VALID(v4), .OUT_DATA(d4), .OUT_READY(out_ready), .OCC(c4));

  logic        ov  [NI];
  logic        orr [NI];
  logic [63:0] od  [NI];
  int          oc  [NI];

  always_comb begin
    ov[0] = v0;  ov[1] = v1;  ov[2] = v2;  ov[3] = v3;  ov[4] = v4;
    orr[0] = r0; orr[1] = r1; orr[2] = r2; orr[3] = r3; orr[4] = r4;
    od[0] = 64'(d0); od[1] = 64'(d1); od[2] = 64'(d2); od[3] = 64'(d3); od[4] = d4;
    oc[0] = int'(c0); oc[1] = int'(c1); oc[2] = int'(c2); oc[3] = int'(c3); oc[4] = int'(c4);
  end

  // Reference model: per instance, an oldest-first list of beats with their stage position.
  int          dep  [NI];
  int          wid  [NI];
  int          cnt  [NI];
  int          bp   [NI][MAXD];
  logic [63:0] bd   [NI][MAXD];
  logic [63:0] last [NI];
  int          tests, fails;

  function automatic logic [63:0] msk(int k);
    return (wid[k] >= 64) ? {64{1'b1}} : ((64'd1 << wid[k]) - 64'd1);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      cnt[k]  = 0;
      last[k] = drst & msk(k);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < NI; k++) begin
      if (cnt[k] > 0 && bp[k][0] == dep[k] - 1 && out_ready) begin
        for (int j = 1; j < cnt[k]; j++) begin
          bp[k][j-1] = bp[k][j];
          bd[k][j-1] = bd[k][j];
        end
        cnt[k]--;
      end
      if (flush) begin
        cnt[k] = 0;
      end else begin
        for (int j = 0; j < cnt[k]; j++) begin
          int lim;
          lim = (j == 0) ? dep[k] : bp[k][j-1];
          if (bp[k][j] + 1 < lim) begin
            bp[k][j]++;
            if (bp[k][j] == dep[k] - 1) last[k] = bd[k][j];
          end
        end
        if (in_valid && (cnt[k] == 0 || bp[k][cnt[k]-1] > 0)) begin
          bd[k][cnt[k]] = in_data & msk(k);
          bp[k][cnt[k]] = 0;
          if (dep[k] == 1) last[k] = in_data & msk(k);
          cnt[k]++;
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rstn) model_step();
    @(negedge clk);
  endtask

  task automatic drain();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (6) cycle();
  endtask

  task automatic test_reset();
    drst = 64'hA5; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    model_reset();
    #1;
    tests++; if (ov[0] !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0h want 0", ov[0]); end
    tests++; if (od[0] !== 64'hA5) begin fails++; $display("FAIL reset_data: got %0h want a5", od[0]); end
    tests++; if (oc[0] !== 0) begin fails++; $display("FAIL reset_occ: got %0d want 0", oc[0]); end
    tests++; if (orr[0] !== 1'b1) begin fails++; $display("FAIL reset_ready: got %0h want 1", orr[0]); end
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h11; cycle();
    in_data = 64'h22; cycle();
    #1;
    tests++; if (oc[0] !== 2) begin fails++; $display("FAIL midstream_occ: got %0d want 2", oc[0]); end
    #2 rstn = 1'b0;
    #1;
    tests++; if (ov[0] !== 1'b0) begin fails++; $display("FAIL async_rst_valid: got %0h want 0", ov[0]); end
    tests++; if (od[0] !== 64'hA5) begin fails++; $display("FAIL async_rst_data: got %0h want a5", od[0]); end
    tests++; if (oc[0] !== 0) begin fails++; $display("FAIL async_rst_occ: got %0d want 0", oc[0]); end
    tests++; if (orr[0] !== 1'b1) begin fails++; $display("FAIL async_rst_ready: got %0h want 1", orr[0]); end
    in_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
  endtask

  task automatic test_streaming();
    drain();
    for (int w = 0; w < 8; w++) begin
      logic ev;
      in_valid = (w < 4);
      in_data  = 64'(w + 1);
      #1;
      ev = (w >= 3 && w <= 6);
      tests++; if (orr[0] !== 1'b1) begin fails++; $display("FAIL stream_ready w%0d: got %0h want 1", w, orr[0]); end
      tests++; if (ov[0] !== ev) begin fails++; $display("FAIL stream_valid w%0d: got %0h want %0h", w, ov[0], ev); end
      if (ev) begin
        tests++;
        if (od[0] !== 64'(w - 2)) begin fails++; $display("FAIL stream_data w%0d: got %0h want %0h", w, od[0], w - 2); end
      end
      cycle();
    end
  endtask

  task automatic test_backpressure();
    int acc, n;
    logic [63:0] got [8];
    drain();
    out_ready = 1'b0; acc = 0; n = 0;
    for (int w = 0; w < 8; w++) begin
      in_valid = (acc < 5);
      in_data  = 64'h10 + 64'(acc);
      #1;
      if (in_valid && orr[0]) acc++;
      cycle();
    end
    #1;
    tests++; if (acc !== 3) begin fails++; $display("FAIL bp_accepted: got %0d want 3", acc); end
    tests++; if (oc[0] !== 3) begin fails++; $display("FAIL bp_occ: got %0d want 3", oc[0]); end
    tests++; if (orr[0] !== 1'b0) begin fails++; $display("FAIL bp_ready: got %0h want 0", orr[0]); end
    tests++; if (od[0] !== 64'h10) begin fails++; $display("FAIL bp_head: got %0h want 10", od[0]); end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int w = 0; w < 6; w++) begin
      #1;
      if (ov[0] && n < 8) begin got[n] = od[0]; n++; end
      cycle();
    end
    tests++; if (n !== 3) begin fails++; $display("FAIL bp_drain_count: got %0d want 3", n); end
    for (int i = 0; i < 3 && i < n; i++) begin
      tests++;
      if (got[i] !== 64'h10 + 64'(i)) begin fails++; $display("FAIL bp_order %0d: got %0h want %0h", i, got[i], 64'h10 + 64'(i)); end
    end
  endtask

  task automatic test_bubble();
    drain();
    out_ready = 1'b0;
    for (int w = 0; w < 7; w++) begin
      in_valid = (w == 0 || w == 3);
      in_data  = (w == 0) ? 64'hAA : 64'hBB;
      cycle();
    end
    in_valid = 1'b0;
    #1;
    tests++; if (oc[1] !== 2) begin fails++; $display("FAIL bubble_occ: got %0d want 2", oc[1]); end
    tests++; if (orr[1] !== 1'b1) begin fails++; $display("FAIL bubble_ready: got %0h want 1", orr[1]); end
    tests++; if (od[1] !== 64'hAA) begin fails++; $display("FAIL bubble_head: got %0h want aa", od[1]); end
    out_ready = 1'b1;
    cycle();
    #1;
    tests++; if (ov[1] !== 1'b1) begin fails++; $display("FAIL bubble_adjacent_valid: got %0h want 1", ov[1]); end
    tests++; if (od[1] !== 64'hBB) begin fails++; $display("FAIL bubble_adjacent_data: got %0h want bb", od[1]); end
  endtask

  task automatic test_flush();
    drain();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int w = 0; w < 3; w++) begin
      in_data = 64'h31 + 64'(w);
      cycle();
    end
    #1;
    tests++; if (oc[0] !== 3) begin fails++; $display("FAIL flush_pre_occ: got %0d want 3", oc[0]); end
    out_ready = 1'b1; flush = 1'b1; in_data = 64'h77;
    #1;
    tests++; if (orr[0] !== 1'b1) begin fails++; $display("FAIL flush_ready: got %0h want 1", orr[0]); end
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    tests++; if (oc[0] !== 0) begin fails++; $display("FAIL flush_occ: got %0d want 0", oc[0]); end
    tests++; if (ov[0] !== 1'b0) begin fails++; $display("FAIL flush_valid: got %0h want 0", ov[0]); end
    tests++; if (od[0] !== 64'h31) begin fails++; $display("FAIL flush_data: got %0h want 31", od[0]); end
    for (int w = 0; w < 4; w++) begin
      cycle();
      #1;
      tests++; if (ov[0] !== 1'b0) begin fails++; $display("FAIL flush_lost w%0d: got %0h want 0", w, ov[0]); end
    end
  endtask

  task automatic test_random();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drst = {$urandom, $urandom};
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      in_data   = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 99) < 65);
      flush     = ($urandom_range(0, 99) < 4);
      #1;
      for (int k = 0; k < NI; k++) begin
        logic        ev, er;
        logic [63:0] ed;
        ev = (cnt[k] > 0) && (bp[k][0] == dep[k] - 1);
        ed = ev ? bd[k][0] : last[k];
        er = (cnt[k] < dep[k]) || out_ready;
        tests++; if (ov[k] !== ev) begin fails++; $display("FAIL rnd_valid i%0d c%0d: got %0h want %0h", k, cyc, ov[k], ev); end
        tests++; if (od[k] !== ed) begin fails++; $display("FAIL rnd_data i%0d c%0d: got %0h want %0h", k, cyc, od[k], ed); end
        tests++; if (orr[k] !== er) begin fails++; $display("FAIL rnd_ready i%0d c%0d: got %0h want %0h", k, cyc, orr[k], er); end
        tests++; if (oc[k] !== cnt[k]) begin fails++; $display("FAIL rnd_occ i%0d c%0d: got %0d want %0d", k, cyc, oc[k], cnt[k]); end
      end
      cycle();
    end
  endtask

  initial begin
    dep[0] = 3; dep[1] = 4; dep[2] = 1; dep[3] = 2; dep[4] = 5;
    wid[0] = 8; wid[1] = 8; wid[2] = 1; wid[3] = 8; wid[4] = 64;
    tests = 0; fails = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble();
    test_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
